// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes reg-write/read and ALU command frames into
// register-file, ALU and TX FIFO strobes. Define CTRL_TIMEOUT_EN for the inter-byte timeout.
module uart_cmd_ctrl #(
  parameter int DATA_WID    = 8,
  parameter int ADDR_WID    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WID-1:0]   RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WID-1:0]   RF_RD_DATA,
  input  logic                  RF_RD_DATA_VLD,
  input  logic [2*DATA_WID-1:0] ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  FIFO_FULL,
  output logic [ADDR_WID-1:0]   RF_ADDR,
  output logic [DATA_WID-1:0]   RF_WR_DATA,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_GATE_EN,
  output logic [DATA_WID-1:0]   TX_P_DATA,
  output logic                  TX_D_VLD
);

  localparam logic [DATA_WID-1:0] OPC_WR      = DATA_WID'(8'hAA);
  localparam logic [DATA_WID-1:0] OPC_RD      = DATA_WID'(8'hBB);
  localparam logic [DATA_WID-1:0] OPC_ALU_OP  = DATA_WID'(8'hCC);
  localparam logic [DATA_WID-1:0] OPC_ALU_NOP = DATA_WID'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_LSB, TX_MSB
  } state_e;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e                state_q, state_d;
  logic [ADDR_WID-1:0]   addr_q, addr_d;
  logic [2*DATA_WID-1:0] result_q, result_d;
  logic                  rd_cmd_q, rd_cmd_d;
  logic [ADDR_WID-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WID-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic                  rf_rd_en_q, rf_rd_en_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic                  alu_en_q, alu_en_d;
  logic                  clk_gate_q, clk_gate_d;
  logic [DATA_WID-1:0]   tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;

`ifdef CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    // NOTE: every _d gets a default first, so no path can infer a latch;
    // combinational logic uses blocking '=', the register process uses '<='.
    state_d      = state_q;
    addr_d       = addr_q;
    result_d     = result_q;
    rd_cmd_d     = rd_cmd_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    clk_gate_d   = clk_gate_q;
    tx_data_d    = tx_data_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    tx_vld_d     = 1'b0;

    unique case (state_q)
      IDLE: if (RX_D_VLD) begin
        rd_cmd_d = (RX_P_DATA == OPC_RD);
        if (RX_P_DATA == OPC_WR) state_d = WR_ADDR;
        else if (RX_P_DATA == OPC_RD) state_d = RD_ADDR;
        else if (RX_P_DATA == OPC_ALU_OP) begin
          state_d    = OP_A;
          clk_gate_d = 1'b1;
        end else if (RX_P_DATA == OPC_ALU_NOP) begin
          state_d    = FUN;
          clk_gate_d = 1'b1;
        end
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WID-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        rf_addr_d    = addr_q;
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        addr_d     = RX_P_DATA[ADDR_WID-1:0];
        rf_addr_d  = RX_P_DATA[ADDR_WID-1:0];
        rf_rd_en_d = 1'b1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: if (RF_RD_DATA_VLD) begin
        result_d = (2*DATA_WID)'(RF_RD_DATA);
        state_d  = TX_LSB;
      end
      OP_A: if (RX_D_VLD) begin
        rf_addr_d    = '0;
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = OP_B;
      end
      OP_B: if (RX_D_VLD) begin
        rf_addr_d    = ADDR_WID'(1);
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = FUN;
      end
      FUN: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[3:0];
        alu_en_d  = 1'b1;
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: if (ALU_OUT_VLD) begin
        result_d   = ALU_OUT;
        clk_gate_d = 1'b0;
        state_d    = TX_LSB;
      end
      // The FIFO write is issued only from an edge that saw FIFO_FULL low;
      // TX_P_DATA changes only together with the strobe.
      TX_LSB: if (!FIFO_FULL) begin
        tx_data_d = result_q[DATA_WID-1:0];
        tx_vld_d  = 1'b1;
        state_d   = rd_cmd_q ? IDLE : TX_MSB;
      end
      TX_MSB: if (!FIFO_FULL) begin
        tx_data_d = result_q[2*DATA_WID-1:DATA_WID];
        tx_vld_d  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef CTRL_TIMEOUT_EN
    tmo_cnt_d = '0;
    if (state_q inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN} && !RX_D_VLD) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d    = IDLE;
        addr_d     = '0;
        clk_gate_d = 1'b0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      result_q     <= '0;
      rd_cmd_q     <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_fun_q    <= '0;
      alu_en_q     <= 1'b0;
      clk_gate_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_vld_q     <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      result_q     <= result_d;
      rd_cmd_q     <= rd_cmd_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_fun_q    <= alu_fun_d;
      alu_en_q     <= alu_en_d;
      clk_gate_q   <= clk_gate_d;
      tx_data_q    <= tx_data_d;
      tx_vld_q     <= tx_vld_d;
`ifdef CTRL_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign RF_ADDR     = rf_addr_q;
  assign RF_WR_DATA  = rf_wr_data_q;
  assign RF_WR_EN    = rf_wr_en_q;
  assign RF_RD_EN    = rf_rd_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_GATE_EN = clk_gate_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized bench for uart_cmd_ctrl: a command-level model predicts the ordered
// register writes, reads, ALU starts and TX bytes, compared against observed strobes.
module tb_uart_cmd_ctrl;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int TMO = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic [DW-1:0] RF_RD_DATA;
  logic          RF_RD_DATA_VLD;
  logic [2*DW-1:0] ALU_OUT;
  logic          ALU_OUT_VLD;
  logic          FIFO_FULL;
  logic [AW-1:0] RF_ADDR;
  logic [DW-1:0] RF_WR_DATA;
  logic          RF_WR_EN;
  logic          RF_RD_EN;
  logic [3:0]    ALU_FUN;
  logic          ALU_EN;
  logic          CLK_GATE_EN;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;

  always #5 CLK = ~CLK;

  uart_cmd_ctrl #(.DATA_WID(DW), .ADDR_WID(AW), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
    .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA), .RF_WR_EN(RF_WR_EN),
    .RF_RD_EN(RF_RD_EN), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_full_en = 1'b0;

  // Events: writes encoded as addr*256+data; reads as addr; ALU as function; TX as byte.
  logic [31:0] exp_wr[$], obs_wr[$], exp_rd[$], obs_rd[$];
  logic [31:0] exp_alu[$], obs_alu[$], exp_tx[$], obs_tx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (RF_WR_EN) obs_wr.push_back(32'(RF_ADDR) * 256 + 32'(RF_WR_DATA));
    if (RF_RD_EN) obs_rd.push_back(32'(RF_ADDR));
    if (ALU_EN)   obs_alu.push_back(32'(ALU_FUN));
    if (TX_D_VLD) begin
      obs_tx.push_back(32'(TX_P_DATA));
      check("tx_while_full", 32'(FIFO_FULL), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLK);
    if (rand_full_en) FIFO_FULL = ($urandom_range(0, 9) < 3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
    RX_P_DATA = DW'($urandom);
    repeat ($urandom_range(0, 3)) tick();
  endtask

  // Random RX traffic while the controller is waiting; must all be ignored.
  task automatic noise();
    repeat ($urandom_range(0, 4)) begin
      tick();
      RX_P_DATA = DW'($urandom);
      RX_D_VLD  = 1'($urandom_range(0, 1));
    end
    tick();
    RX_D_VLD = 1'b0;
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    tick();
    RF_RD_DATA = d;
    RF_RD_DATA_VLD = 1'b1;
    tick();
    RF_RD_DATA_VLD = 1'b0;
    RF_RD_DATA = DW'($urandom);
  endtask

  task automatic pulse_alu(input logic [15:0] r);
    tick();
    ALU_OUT = r;
    ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    ALU_OUT = 16'($urandom);
  endtask

  task automatic cmp_q(input string tag, input logic [31:0] obs[$], input logic [31:0] exp[$]);
    check({tag, "_count"}, 32'(obs.size()), 32'(exp.size()));
    for (int i = 0; i < obs.size() && i < exp.size(); i++) check(tag, obs[i], exp[i]);
  endtask

  task automatic settle();
    int cyc = 0;
    bit timed_out;
    while (!(obs_wr.size() >= exp_wr.size() && obs_rd.size() >= exp_rd.size() &&
             obs_alu.size() >= exp_alu.size() && obs_tx.size() >= exp_tx.size()) && cyc < 400) begin
      tick();
      cyc++;
    end
    timed_out = (cyc >= 400);
    check("settle_timeout", 32'(timed_out), 32'd0);
    repeat (3) tick();
    cmp_q("rf_write", obs_wr, exp_wr);
    cmp_q("rf_read", obs_rd, exp_rd);
    cmp_q("alu_start", obs_alu, exp_alu);
    cmp_q("tx_byte", obs_tx, exp_tx);
    obs_wr.delete(); exp_wr.delete(); obs_rd.delete(); exp_rd.delete();
    obs_alu.delete(); exp_alu.delete(); obs_tx.delete(); exp_tx.delete();
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA); send_byte(a); send_byte(d);
    exp_wr.push_back(32'(a) % 16 * 256 + 32'(d));
    settle();
  endtask

  task automatic cmd_read(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hBB); send_byte(a);
    noise();
    pulse_rd(d);
    exp_rd.push_back(32'(a) % 16);
    exp_tx.push_back(32'(d));
    settle();
  endtask

  task automatic cmd_alu(input bit with_ops, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] f, input logic [15:0] r);
    if (with_ops) begin
      send_byte(8'hCC); send_byte(x); send_byte(y);
      exp_wr.push_back(0 * 256 + 32'(x));
      exp_wr.push_back(1 * 256 + 32'(y));
    end else begin
      send_byte(8'hDD);
    end
    send_byte(f);
    noise();
    pulse_alu(r);
    exp_alu.push_back(32'(f) % 16);
    exp_tx.push_back(32'(r) % 256);
    exp_tx.push_back(32'(r) / 256);
    settle();
  endtask

  initial begin
    int w;
    logic [7:0] b;
    RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RD_DATA = '0; RF_RD_DATA_VLD = 1'b0;
    ALU_OUT = '0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
    repeat (3) tick();
    check("rst_rf_addr", 32'(RF_ADDR), 0);
    check("rst_rf_wr_data", 32'(RF_WR_DATA), 0);
    check("rst_strobes", {RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD}, 0);
    check("rst_alu_fun", 32'(ALU_FUN), 0);
    check("rst_clk_gate", 32'(CLK_GATE_EN), 0);
    check("rst_tx_data", 32'(TX_P_DATA), 0);

    // First command accepted right after release: AA,05,3C
    RST = 1'b0; RX_P_DATA = 8'hAA; RX_D_VLD = 1'b1;
    tick();
    RX_D_VLD = 1'b0;
    send_byte(8'h05); send_byte(8'h3C);
    exp_wr.push_back(5 * 256 + 8'h3C);
    settle();
    check("hold_rf_addr", 32'(RF_ADDR), 5);
    check("hold_rf_wr_data", 32'(RF_WR_DATA), 32'h3C);

    cmd_read(8'h07, 8'h5A);

    // CC,10,20,02 with clock-gate tracking
    check("gate_before_cc", 32'(CLK_GATE_EN), 0);
    send_byte(8'hCC);
    check("gate_in_op_a", 32'(CLK_GATE_EN), 1);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h02);
    check("gate_in_alu_wait", 32'(CLK_GATE_EN), 1);
    pulse_alu(16'h0200);
    check("gate_after_vld", 32'(CLK_GATE_EN), 0);
    exp_wr.push_back(0 * 256 + 8'h10);
    exp_wr.push_back(1 * 256 + 8'h20);
    exp_alu.push_back(2);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h02);
    settle();
    check("hold_alu_fun", 32'(ALU_FUN), 2);

    // DD,01 with FIFO_FULL stalling TX_MSB for 5 cycles
    send_byte(8'hDD); send_byte(8'h01);
    pulse_alu(16'hABCD);
    w = 0;
    while (obs_tx.size() < 1 && w < 50) begin tick(); w++; end
    check("lsb_seen_timeout", 32'(w >= 50), 0);
    FIFO_FULL = 1'b1;
    repeat (5) begin
      tick();
      check("stall_tx_count", 32'(obs_tx.size()), 1);
      check("stall_tx_data", 32'(TX_P_DATA), 32'hCD);
    end
    FIFO_FULL = 1'b0;
    exp_alu.push_back(1);
    exp_tx.push_back(8'hCD);
    exp_tx.push_back(8'hAB);
    settle();

    // Non-opcode byte in IDLE is dropped
    send_byte(8'h55);
    settle();
    check("gate_after_junk", 32'(CLK_GATE_EN), 0);

    // Reset in OP_B discards the command
    send_byte(8'hCC); send_byte(8'h11);
    exp_wr.push_back(0 * 256 + 8'h11);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("midrst_clk_gate", 32'(CLK_GATE_EN), 0);
    check("midrst_rf_addr", 32'(RF_ADDR), 0);
    check("midrst_rf_wr_data", 32'(RF_WR_DATA), 0);
    settle();
    cmd_write(8'h0C, 8'h77);

`ifdef CTRL_TIMEOUT_EN
    send_byte(8'hAA);
    repeat (TMO + 4) tick();
    send_byte(8'h3C);
    settle();
    send_byte(8'hDD);
    repeat (TMO + 4) tick();
    check("tmo_clk_gate", 32'(CLK_GATE_EN), 0);
    settle();
    cmd_write(8'h03, 8'h99);
`endif

    rand_full_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: cmd_write(8'($urandom), 8'($urandom));
        1: cmd_read(8'($urandom), 8'($urandom));
        2: cmd_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
        3: cmd_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom));
        default: begin
          do b = 8'($urandom); while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
          send_byte(b);
          settle();
        end
      endcase
    end
    rand_full_en = 1'b0;
    FIFO_FULL = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WID, default 8, width of the byte path.
REQ-002 SHALL have parameter ADDR_WID, default 4, width of the register-file address.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, inter-byte timeout in cycles (used only with CTRL_TIMEOUT_EN).
REQ-004 SHALL have one clock and a synchronous, active-high reset; no other clock or reset.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 RX_P_DATA  in  DATA_WID  received byte from the UART receiver.
REQ-008 RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid.
REQ-009 RF_RD_DATA  in  DATA_WID  register-file read data.
REQ-010 RF_RD_DATA_VLD  in  1  read data valid strobe.
REQ-011 ALU_OUT  in  2*DATA_WID  ALU result.
REQ-012 ALU_OUT_VLD  in  1  ALU result valid strobe.
REQ-013 FIFO_FULL  in  1  TX FIFO full; no write allowed.
REQ-014 RF_ADDR  out  ADDR_WID  register-file address.
REQ-015 RF_WR_DATA  out  DATA_WID  register-file write data.
REQ-016 RF_WR_EN / RF_RD_EN  out  1 each  one-cycle register-file strobes.
REQ-017 ALU_FUN  out  4  ALU function select; ALU_EN  out  1  one-cycle ALU start.
REQ-018 CLK_GATE_EN  out  1  ALU clock-gate enable.
REQ-019 TX_P_DATA  out  DATA_WID  byte to TX FIFO; TX_D_VLD  out  1  one-cycle FIFO write strobe.

Function
REQ-020 Opcodes, accepted only in IDLE on RX_D_VLD: 0xAA reg-write, 0xBB reg-read, 0xCC ALU with operands, 0xDD ALU without operands; any other byte is dropped and the FSM stays in IDLE.
REQ-021 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_LSB, TX_MSB.
REQ-022 All outputs registered; each strobe is high exactly one cycle, in the cycle after the edge that samples the causing RX_D_VLD or VLD input.
REQ-023 0xAA: WR_ADDR latches RX_P_DATA[ADDR_WID-1:0]; WR_DATA then pulses RF_WR_EN with the latched address and the data byte; -> IDLE.
REQ-024 0xBB: RD_ADDR pulses RF_RD_EN with the received address; -> RD_WAIT; on RF_RD_DATA_VLD latch the byte; -> TX_LSB; after the write -> IDLE (no TX_MSB).
REQ-025 0xCC: OP_A pulses RF_WR_EN to address 0 with the byte; OP_B pulses RF_WR_EN to address 1; -> FUN.
REQ-026 0xDD: IDLE -> FUN directly.
REQ-027 FUN: on RX_D_VLD, drive ALU_FUN = byte[3:0] and pulse ALU_EN; -> ALU_WAIT; on ALU_OUT_VLD latch 16 bits; -> TX_LSB (bits 7:0) -> TX_MSB (bits 15:8) -> IDLE.
REQ-028 CLK_GATE_EN rises on entry to OP_A (0xCC) or FUN (0xDD) and falls the cycle after ALU_OUT_VLD is sampled.
REQ-029 TX_LSB/TX_MSB: TX_D_VLD pulses only in a cycle where FIFO_FULL is low; while FIFO_FULL is high the state holds and TX_P_DATA is stable; no byte is lost or duplicated.
REQ-030 RX_D_VLD in RD_WAIT, ALU_WAIT, TX_LSB or TX_MSB is ignored and the byte is dropped.
REQ-031 RF_ADDR, RF_WR_DATA and ALU_FUN hold their last values between strobes.

Reset
REQ-032 RST high at a rising edge forces IDLE, all outputs 0, latched address/data/result cleared, and the timeout counter at 0, including mid-command or mid-TX.
REQ-033 The first command is accepted in the cycle after RST is released.

Configuration
REQ-034 Macro CTRL_TIMEOUT_EN defined: in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and FUN, a counter clears on each RX_D_VLD; at TIMEOUT_CYC idle cycles -> IDLE, partial command discarded, no strobe, CLK_GATE_EN low.
REQ-035 Macro undefined: no counter is built; collecting states wait indefinitely.

Verification
REQ-036 AA,05,3C -> one RF_WR_EN pulse, RF_ADDR=5, RF_WR_DATA=0x3C; FSM in IDLE.
REQ-037 BB,07 then RF_RD_DATA=0x5A with VLD -> RF_RD_EN pulse with addr 7; one TX_D_VLD with 0x5A.
REQ-038 CC,10,20,02 then ALU_OUT=0x0200 with VLD -> writes 0x10@0 and 0x20@1; ALU_FUN=2 with an ALU_EN pulse; TX 0x00 then 0x02; CLK_GATE_EN high from OP_A through VLD.
REQ-039 DD,01 with ALU_OUT=0xABCD and FIFO_FULL high for 5 cycles before TX_MSB -> TX 0xCD; TX_MSB stalls 5 cycles; then exactly one 0xAB.
REQ-040 Byte 0x55 in IDLE; RST asserted in OP_B; with CTRL_TIMEOUT_EN, AA then silence for TIMEOUT_CYC cycles -> no strobes, IDLE in every case, next AA command works.
